csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
Machine-mode CSR file and trap controller for the RV32 core, generalised to NUM_IRQ edge-latched platform interrupt lines (UART TX/RX, timers, GPIO) on mip/mie bits 16 and up.
- Adds full mstatus MIE/MPIE stacking, CSR set/clear operations, fixed-priority arbitration and optional vectored mtvec.
- Sits beside the decode/execute stage.
- Drives epc/epc_taken into PC-select logic.

Parameters:
NUM_IRQ, 4, number of platform interrupt lines; legal range 1..16; mapped to mip/mie bits [16+NUM_IRQ-1:16].
VECTORED_EN, 1, 1 = mtvec MODE 1 (vectored) is legal; 0 = MODE is forced to 0.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-low reset
pc  input  32  PC of the instruction currently in execute
instr_valid  input  1  execute stage holds a valid, non-stalled instruction; traps are taken only when high
csr_addr  input  12  CSR address
csr_rd  input  1  read enable
csr_wr  input  1  write enable
csr_op  input  2  01 write, 10 set (OR), 11 clear (AND-NOT), 00 no-op
wd  input  32  write data / mask
rd  output  32  read data
is_mret  input  1  MRET in execute
t_inter  input  1  machine timer interrupt, level
e_inter  input  1  machine external interrupt, level
irq_lines  input  NUM_IRQ  platform interrupt lines, rising-edge sensitive
epc  output  32  redirect target
epc_taken  output  1  redirect valid this cycle

Behaviour:
- All state updates on posedge clk. rst low forces:
  - mstatus, mie, mtvec, mepc, mcause, mscratch and the platform pending latches to 0.
  - irq_prev <= irq_lines, so a line already high at reset release is not an edge.
- rd and epc_taken are 0 during reset. epc is 0 whenever epc_taken is 0.
- CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344.
- Reads:
  - Combinational, same cycle. rd = 0 when csr_rd is low or the address is unimplemented.
  - Writes take effect at the next edge and are visible on reads one cycle later.
- mstatus:
  - Only MIE[3] and MPIE[7] are writable.
  - MPP[12:11] reads as 2'b11. All other bits read as 0.
- mie: only bits 7, 11 and 16..16+NUM_IRQ-1 are writable; all others read as 0.
- mtvec:
  - BASE[31:2] is writable.
  - MODE[1:0] stores wd[1:0] only if wd[1:0]==01 and VECTORED_EN=1; otherwise it stores 00.
- mepc: bits [1:0] always read as 0.
- mip:
  - Bit 7 = t_inter and bit 11 = e_inter, read-only level mirrors.
  - Bit 16+i = pending latch i:
    - Set on an irq_lines[i] 0->1 edge.
    - Cleared by a CSR write/clear to mip with that bit effectively 0, or by trap entry for source i.
    - If an edge and a clear happen in the same cycle, set wins.
- Pending vector: P = mip & mie, gated by mstatus.MIE.
- Priority, highest first: MEIP (cause 11), MTIP (cause 7), then platform i=0 (cause 16) upward.
- Trap entry, when P != 0 and instr_valid:
  - Same cycle: epc_taken = 1; epc = BASE<<2 in direct mode, or (BASE<<2) + 4*cause in vectored mode.
  - Next edge: mepc <= pc; mcause <= {1'b1, 31'(cause)}; MPIE <= MIE; MIE <= 0; the winning platform latch is cleared.
- MRET, when is_mret and no trap is taken:
  - Same cycle: epc_taken = 1 and epc = mepc.
  - Next edge: MIE <= MPIE; MPIE <= 1. mcause is unchanged.
- Simultaneous events:
  - Trap and MRET in the same cycle: the trap wins, mepc <= pc of the MRET, and MPIE <= current MIE.
  - Trap and CSR write in the same cycle: the trap updates to mstatus, mepc and mcause override the CSR write. Writes to other CSRs proceed.
- instr_valid low: no trap is taken, but pending latches still capture edges.
- Single-cycle trap latency from a qualified pending condition to redirect. No internal FSM beyond the latches and the mstatus stack.

Decomposition:
- csr_pkg holds:
  - CSR address localparams.
  - Cause-code constants (11, 7, 16).
  - csr_op_e enum.
  - MSTATUS_MIE_BIT and MSTATUS_MPIE_BIT indices.
- Sub-module irq_prio_enc (parametrised by width 2+NUM_IRQ) takes the masked pending vector and outputs valid, cause[4:0] and a one-hot grant. It is reused by the future PLIC.

Test Plan:
1. Reset with irq_lines=4'b0001 held high, then release -> mip[16]=0 and no trap.
2. mtvec=0x0000_1001 (vectored), mie=0x0001_0000, mstatus=0x8; pulse irq_lines[0] -> the next instr_valid cycle has epc_taken=1 and epc=0x0000_1040; next cycle mepc=pc, mcause=0x8000_0010, mstatus MIE=0, MPIE=1, mip[16]=0.
3. e_inter=1, t_inter=1, irq_lines[2] edge, all enabled -> cause 11 taken first; after MRET (epc=mepc, MIE restored to 1) cause 7 is taken next.
4. CSR set mie with wd=0x0000_0880, then CSR clear with wd=0x80 -> mie reads 0x0000_0800; write mstatus 0xFFFF_FFFF -> reads 0x0000_1888.
5. Trap pending coincident with is_mret and a csr write of mstatus=0 -> trap taken, mstatus MIE=0, MPIE=old MIE, mepc=pc.
6. VECTORED_EN=0, write mtvec=0x2001 -> reads 0x2000; an irq edge with instr_valid=0 for 3 cycles -> no redirect until instr_valid rises, then epc=0x2000.

Source files
------------

// File: rtl/csr_pkg.sv
// +----------------------------------------------------------------------+
// | csr_pkg : CSR addresses, cause codes and op encoding. Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   localparam logic [4:0] CAUSE_MEI       = 5'd11;
   localparam logic [4:0] CAUSE_MTI       = 5'd7;
   localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

   typedef enum logic [1:0] {
      CSR_NOP   = 2'b00,
      CSR_WRITE = 2'b01,
      CSR_SET   = 2'b10,
      CSR_CLEAR = 2'b11
   } csr_op_e;

   function automatic logic [31:0] csr_apply(input csr_op_e op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] wd);
      case (op)
         CSR_WRITE: return wd;
         CSR_SET:   return old_val | wd;
         CSR_CLEAR: return old_val & ~wd;
         default:   return old_val;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// +----------------------------------------------------------------------+
// | irq_prio_enc : fixed-priority encoder, bit 0 highest. Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_prio_enc
   import csr_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] pending,
   output logic             valid,
   output logic [4:0]       cause,
   output logic [WIDTH-1:0] grant
);

   // Index 0 is MEIP, index 1 is MTIP, index 2.. are platform lines.
   function automatic logic [4:0] idx_to_cause(input int idx);
      if (idx == 0) begin
         return CAUSE_MEI;
      end else if (idx == 1) begin
         return CAUSE_MTI;
      end else begin
         return CAUSE_PLAT_BASE + 5'(idx - 2);
      end
   endfunction

   always_comb begin
      valid = |pending;
      cause = 5'd0;
      grant = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending[i]) begin
            cause    = idx_to_cause(i);
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
// +----------------------------------------------------------------------+
// | csr_trap_ctrl : machine-mode CSR file and trap controller. Rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module csr_trap_ctrl
   import csr_pkg::*;
#(
   parameter int NUM_IRQ     = 4,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        pc,
   input  logic               instr_valid,
   input  logic [11:0]        csr_addr,
   input  logic               csr_rd,
   input  logic               csr_wr,
   input  logic [1:0]         csr_op,
   input  logic [31:0]        wd,
   output logic [31:0]        rd,
   input  logic               is_mret,
   input  logic               t_inter,
   input  logic               e_inter,
   input  logic [NUM_IRQ-1:0] irq_lines,
   output logic [31:0]        epc,
   output logic               epc_taken
);

   localparam int PRIO_W = 2 + NUM_IRQ;
   localparam logic [31:0] MIE_MASK =
      32'h0000_0880 | (((32'h1 << NUM_IRQ) - 32'h1) << 16);

   logic               mie_bit_q,  mie_bit_d;
   logic               mpie_bit_q, mpie_bit_d;
   logic [31:0]        mie_q,      mie_d;
   logic [31:0]        mtvec_q,    mtvec_d;
   logic [31:0]        mscratch_q, mscratch_d;
   logic [31:0]        mepc_q,     mepc_d;
   logic [31:0]        mcause_q,   mcause_d;
   logic [NUM_IRQ-1:0] pend_q,     pend_d;
   logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;

   logic [31:0]        w_mstatus;
   logic [31:0]        w_mip;
   logic [31:0]        w_csr_view;
   logic [31:0]        w_new;
   logic               w_wr;
   logic [PRIO_W-1:0]  w_pend_vec;
   logic               w_irq_valid;
   logic [4:0]         w_cause;
   logic [PRIO_W-1:0]  w_grant;
   logic               w_grant_core;
   logic               w_trap;
   logic               w_mret;
   logic [NUM_IRQ-1:0] w_edge;

   always_comb begin
      w_mstatus                   = 32'h0;
      w_mstatus[MSTATUS_MIE_BIT]  = mie_bit_q;
      w_mstatus[MSTATUS_MPIE_BIT] = mpie_bit_q;
      w_mstatus[12:11]            = MSTATUS_MPP_M;

      w_mip     = 32'(pend_q) << 16;
      w_mip[7]  = t_inter;
      w_mip[11] = e_inter;

      case (csr_addr)
         CSR_MSTATUS:  w_csr_view = w_mstatus;
         CSR_MIE:      w_csr_view = mie_q;
         CSR_MTVEC:    w_csr_view = mtvec_q;
         CSR_MSCRATCH: w_csr_view = mscratch_q;
         CSR_MEPC:     w_csr_view = mepc_q;
         CSR_MCAUSE:   w_csr_view = mcause_q;
         CSR_MIP:      w_csr_view = w_mip;
         default:      w_csr_view = 32'h0;
      endcase

      rd    = (rst && csr_rd) ? w_csr_view : 32'h0;
      w_wr  = rst && csr_wr && (csr_op_e'(csr_op) != CSR_NOP);
      w_new = csr_apply(csr_op_e'(csr_op), w_csr_view, wd);
   end

   // Global MIE gates the whole masked vector before arbitration.
   assign w_pend_vec = {pend_q & mie_q[16 +: NUM_IRQ],
                        t_inter & mie_q[7],
                        e_inter & mie_q[11]} & {PRIO_W{mie_bit_q}};

   irq_prio_enc #(
      .WIDTH (PRIO_W)
   ) u_prio (
      .pending (w_pend_vec),
      .valid   (w_irq_valid),
      .cause   (w_cause),
      .grant   (w_grant)
   );

   assign w_grant_core = |w_grant[1:0];
   assign w_trap       = rst && instr_valid && w_irq_valid;
   assign w_mret       = rst && is_mret && !w_trap;
   assign w_edge       = irq_lines & ~irq_prev_q;

   always_comb begin
      epc_taken = w_trap || w_mret;
      epc       = 32'h0;
      if (w_trap) begin
         epc = {mtvec_q[31:2], 2'b00} +
               ((mtvec_q[1:0] == 2'b01) ? {25'd0, w_cause, 2'b00} : 32'h0);
      end else if (w_mret) begin
         epc = mepc_q;
      end
   end

   always_comb begin
      mie_bit_d  = mie_bit_q;
      mpie_bit_d = mpie_bit_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      pend_d     = pend_q;
      irq_prev_d = irq_lines;

      if (w_wr) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mie_bit_d  = w_new[MSTATUS_MIE_BIT];
               mpie_bit_d = w_new[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:      mie_d      = w_new & MIE_MASK;
            CSR_MTVEC:    mtvec_d    = {w_new[31:2],
                                        (VECTORED_EN && (w_new[1:0] == 2'b01)) ? 2'b01 : 2'b00};
            CSR_MSCRATCH: mscratch_d = w_new;
            CSR_MEPC:     mepc_d     = w_new & 32'hFFFF_FFFC;
            CSR_MCAUSE:   mcause_d   = w_new;
            CSR_MIP:      pend_d     = pend_q & w_new[16 +: NUM_IRQ];
            default: ;
         endcase
      end

      if (w_mret) begin
         mie_bit_d  = mpie_bit_q;
         mpie_bit_d = 1'b1;
      end

      // Trap entry overrides any coincident CSR write or MRET stacking.
      if (w_trap) begin
         mpie_bit_d = mie_bit_q;
         mie_bit_d  = 1'b0;
         mepc_d     = pc & 32'hFFFF_FFFC;
         mcause_d   = {1'b1, 26'd0, w_cause};
         if (!w_grant_core) begin
            pend_d = pend_d & ~w_grant[PRIO_W-1:2];
         end
      end

      // A new edge always wins over a same-cycle clear.
      pend_d = pend_d | w_edge;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mie_bit_q  <= 1'b0;
         mpie_bit_q <= 1'b0;
         mie_q      <= 32'h0;
         mtvec_q    <= 32'h0;
         mscratch_q <= 32'h0;
         mepc_q     <= 32'h0;
         mcause_q   <= 32'h0;
         pend_q     <= '0;
         irq_prev_q <= irq_lines;
      end else begin
         mie_bit_q  <= mie_bit_d;
         mpie_bit_q <= mpie_bit_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         pend_q     <= pend_d;
         irq_prev_q <= irq_prev_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_csr_trap_ctrl : directed bench for csr_trap_ctrl. Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_csr_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        instr_valid;
   logic [11:0] csr_addr;
   logic        csr_rd;
   logic        csr_wr;
   logic [1:0]  csr_op;
   logic [31:0] wd;
   logic        is_mret;
   logic        t_inter;
   logic        e_inter;
   logic [3:0]  irq_lines;
   logic [31:0] rd, rd_nv;
   logic [31:0] epc, epc_nv;
   logic        epc_taken, epc_taken_nv;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   csr_trap_ctrl #(.NUM_IRQ(4), .VECTORED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .pc(pc), .instr_valid(instr_valid),
      .csr_addr(csr_addr), .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_op(csr_op),
      .wd(wd), .rd(rd), .is_mret(is_mret), .t_inter(t_inter), .e_inter(e_inter),
      .irq_lines(irq_lines), .epc(epc), .epc_taken(epc_taken)
   );

   csr_trap_ctrl #(.NUM_IRQ(4), .VECTORED_EN(1'b0)) dut_nv (
      .clk(clk), .rst(rst), .pc(pc), .instr_valid(instr_valid),
      .csr_addr(csr_addr), .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_op(csr_op),
      .wd(wd), .rd(rd_nv), .is_mret(is_mret), .t_inter(t_inter), .e_inter(e_inter),
      .irq_lines(irq_lines), .epc(epc_nv), .epc_taken(epc_taken_nv)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      csr_wr   = 1'b1;
      csr_addr = a;
      csr_op   = op;
      wd       = d;
      tick();
      csr_wr   = 1'b0;
      csr_op   = 2'b00;
      wd       = 32'h0;
   endtask

   task automatic csr_read(input logic [11:0] a, output logic [31:0] v, output logic [31:0] v_nv);
      csr_rd   = 1'b1;
      csr_addr = a;
      #1;
      v        = rd;
      v_nv     = rd_nv;
      csr_rd   = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v, vn;
      rst = 1'b0; irq_lines = 4'b0001; instr_valid = 1'b1; is_mret = 1'b1;
      csr_rd = 1'b1; csr_addr = 12'h300;
      tick(); tick(); tick();
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h expected %h", rd, 32'h0); end
      n_checks++;
      if (epc_taken !== 1'b0) begin n_fail++; $display("FAIL reset_epc_taken: got %b expected 0", epc_taken); end
      rst = 1'b1; is_mret = 1'b0; csr_rd = 1'b0;
      tick(); tick();
      n_checks++;
      if (epc_taken !== 1'b0 || epc !== 32'h0) begin
         n_fail++; $display("FAIL reset_no_trap: got taken=%b epc=%h expected 0/0", epc_taken, epc);
      end
      instr_valid = 1'b0;
      csr_read(12'h344, v, vn);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mip: got %h expected %h", v, 32'h0); end
      csr_read(12'h300, v, vn);
      n_checks++;
      if (v !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus: got %h expected %h", v, 32'h0000_1800); end
   endtask

   task automatic test_vectored_trap();
      logic [31:0] v, vn;
      csr_write(12'h305, 2'b01, 32'h0000_1001);
      csr_write(12'h304, 2'b01, 32'h0001_0000);
      csr_write(12'h300, 2'b01, 32'h0000_0008);
      irq_lines = 4'b0000; tick();
      irq_lines = 4'b0001; tick();
      csr_read(12'h344, v, vn);
      n_checks++;
      if (v !== 32'h0001_0000) begin n_fail++; $display("FAIL plat_pending: got %h expected %h", v, 32'h0001_0000); end
      pc = 32'h0000_0100; instr_valid = 1'b1;
      #1;
      n_checks++;
      if (epc_taken !== 1'b1 || epc !== 32'h0000_1040) begin
         n_fail++; $display("FAIL vec_redirect: got taken=%b epc=%h expected 1/%h", epc_taken, epc, 32'h0000_1040);
      end
      tick();
      instr_valid = 1'b0;
      csr_read(12'h341, v, vn);
      n_checks++;
      if (v !== 32'h0000_0100) begin n_fail++; $display("FAIL vec_mepc: got %h expected %h", v, 32'h0000_0100); end
      csr_read(12'h342, v, vn);
      n_checks++;
      if (v !== 32'h8000_0010) begin n_fail++; $display("FAIL vec_mcause: got %h expected %h", v, 32'h8000_0010); end
      csr_read(12'h300, v, vn);
      n_checks++;
      if (v !== 32'h0000_1880) begin n_fail++; $display("FAIL vec_mstatus: got %h expected %h", v, 32'h0000_1880); end
      csr_read(12'h344, v, vn);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL vec_mip_cleared: got %h expected %h", v, 32'h0); end
   endtask

   task automatic test_priority_mret();
      logic [31:0] v, vn;
      csr_write(12'h304, 2'b01, 32'h0004_0880);
      csr_write(12'h300, 2'b01, 32'h0000_0008);
      e_inter = 1'b1; t_inter = 1'b1; irq_lines = 4'b0101; tick();
      pc = 32'h0000_0200; instr_valid = 1'b1;
      #1;
      n_checks++;
      if (epc_taken !== 1'b1 || epc !== 32'h0000_102C) begin
         n_fail++; $display("FAIL prio_mei_epc: got taken=%b epc=%h expected 1/%h", epc_taken, epc, 32'h0000_102C);
      end
      tick();
      instr_valid = 1'b0;
      csr_read(12'h342, v, vn);
      n_checks++;
      if (v !== 32'h8000_000B) begin n_fail++; $display("FAIL prio_mei_cause: got %h expected %h", v, 32'h8000_000B); end
      e_inter = 1'b0; is_mret = 1'b1; instr_valid = 1'b1; pc = 32'h0000_0204;
      #1;
      n_checks++;
      if (epc_taken !== 1'b1 || epc !== 32'h0000_0200) begin
         n_fail++; $display("FAIL mret_epc: got taken=%b epc=%h expected 1/%h", epc_taken, epc, 32'h0000_0200);
      end
      tick();
      is_mret = 1'b0; instr_valid = 1'b0;
      csr_read(12'h300, v, vn);
      n_checks++;
      if (v !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus: got %h expected %h", v, 32'h0000_1888); end
      csr_read(12'h342, v, vn);
      n_checks++;
      if (v !== 32'h8000_000B) begin n_fail++; $display("FAIL mret_mcause_kept: got %h expected %h", v, 32'h8000_000B); end
      pc = 32'h0000_0300; instr_valid = 1'b1;
      #1;
      n_checks++;
      if (epc_taken !== 1'b1 || epc !== 32'h0000_101C) begin
         n_fail++; $display("FAIL prio_mti_epc: got taken=%b epc=%h expected 1/%h", epc_taken, epc, 32'h0000_101C);
      end
      tick();
      instr_valid = 1'b0; t_inter = 1'b0;
      csr_read(12'h342, v, vn);
      n_checks++;
      if (v !== 32'h8000_0007) begin n_fail++; $display("FAIL prio_mti_cause: got %h expected %h", v, 32'h8000_0007); end
   endtask

   task automatic test_set_clear();
      logic [31:0] v, vn;
      csr_write(12'h304, 2'b01, 32'h0);
      csr_write(12'h304, 2'b10, 32'h0000_0880);
      csr_write(12'h304, 2'b11, 32'h0000_0080);
      csr_read(12'h304, v, vn);
      n_checks++;
      if (v !== 32'h0000_0800) begin n_fail++; $display("FAIL mie_set_clear: got %h expected %h", v, 32'h0000_0800); end
      csr_write(12'h300, 2'b01, 32'hFFFF_FFFF);
      csr_read(12'h300, v, vn);
      n_checks++;
      if (v !== 32'h0000_1888) begin n_fail++; $display("FAIL mstatus_warl: got %h expected %h", v, 32'h0000_1888); end
   endtask

   task automatic test_collision();
      logic [31:0] v, vn;
      csr_write(12'h304, 2'b01, 32'h0004_0000);
      pc = 32'h0000_0400; instr_valid = 1'b1; is_mret = 1'b1;
      csr_wr = 1'b1; csr_addr = 12'h300; csr_op = 2'b01; wd = 32'h0;
      #1;
      n_checks++;
      if (epc_taken !== 1'b1 || epc !== 32'h0000_1048) begin
         n_fail++; $display("FAIL coll_epc: got taken=%b epc=%h expected 1/%h", epc_taken, epc, 32'h0000_1048);
      end
      tick();
      instr_valid = 1'b0; is_mret = 1'b0; csr_wr = 1'b0; csr_op = 2'b00;
      csr_read(12'h300, v, vn);
      n_checks++;
      if (v !== 32'h0000_1880) begin n_fail++; $display("FAIL coll_mstatus: got %h expected %h", v, 32'h0000_1880); end
      csr_read(12'h341, v, vn);
      n_checks++;
      if (v !== 32'h0000_0400) begin n_fail++; $display("FAIL coll_mepc: got %h expected %h", v, 32'h0000_0400); end
      csr_read(12'h342, v, vn);
      n_checks++;
      if (v !== 32'h8000_0012) begin n_fail++; $display("FAIL coll_mcause: got %h expected %h", v, 32'h8000_0012); end
      csr_read(12'h344, v, vn);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL coll_mip: got %h expected %h", v, 32'h0); end
   endtask

   task automatic test_direct_mode_stall();
      logic [31:0] v, vn;
      csr_write(12'h305, 2'b01, 32'h0000_2001);
      csr_read(12'h305, v, vn);
      n_checks++;
      if (vn !== 32'h0000_2000) begin n_fail++; $display("FAIL nv_mtvec: got %h expected %h", vn, 32'h0000_2000); end
      n_checks++;
      if (v !== 32'h0000_2001) begin n_fail++; $display("FAIL v_mtvec: got %h expected %h", v, 32'h0000_2001); end
      csr_write(12'h304, 2'b01, 32'h0001_0000);
      csr_write(12'h300, 2'b01, 32'h0000_0008);
      irq_lines = 4'b0100; tick();
      irq_lines = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (epc_taken_nv !== 1'b0 || epc_nv !== 32'h0) begin
            n_fail++; $display("FAIL stall_no_redirect[%0d]: got taken=%b epc=%h expected 0/0", i, epc_taken_nv, epc_nv);
         end
         tick();
      end
      pc = 32'h0000_0500; instr_valid = 1'b1;
      #1;
      n_checks++;
      if (epc_taken_nv !== 1'b1 || epc_nv !== 32'h0000_2000) begin
         n_fail++; $display("FAIL nv_redirect: got taken=%b epc=%h expected 1/%h", epc_taken_nv, epc_nv, 32'h0000_2000);
      end
      n_checks++;
      if (epc !== 32'h0000_2040) begin n_fail++; $display("FAIL v_redirect: got %h expected %h", epc, 32'h0000_2040); end
      tick();
      instr_valid = 1'b0;
      csr_read(12'h342, v, vn);
      n_checks++;
      if (vn !== 32'h8000_0010) begin n_fail++; $display("FAIL nv_mcause: got %h expected %h", vn, 32'h8000_0010); end
   endtask

   initial begin
      rst = 1'b0; pc = 32'h0; instr_valid = 1'b0; csr_addr = 12'h0; csr_rd = 1'b0;
      csr_wr = 1'b0; csr_op = 2'b00; wd = 32'h0; is_mret = 1'b0;
      t_inter = 1'b0; e_inter = 1'b0; irq_lines = 4'b0001;
      test_reset();
      test_vectored_trap();
      test_priority_mret();
      test_set_clear();
      test_collision();
      test_direct_mode_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
